ps2_scan_receiver: RTL and testbench

PS/2 keyboard front end. It synchronises and deglitches the raw PS2C/PS2D lines, deserialises 11-bit device-to-host frames, and checks start, odd-parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into flags and presents one completed scan code per valid pulse. It sits directly between the board pins and the memory-mapped PS/2 register interface, which consumes `o_Key`/`o_Valid` and drives `i_Enable`.

---
 rtl/ps2_scan_receiver_if.sv | 30 +++
 rtl/ps2_scan_receiver.sv | 153 +++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_receiver_if.sv
// PS/2 receiver register-side bundle: enable in, scan code and status out.
interface ps2_scan_receiver_if;
  logic       i_Enable;
  logic [7:0] o_Key;
  logic       o_Valid;
  logic       o_Break;
  logic       o_Ext;
  logic       o_Err;
  logic       o_Busy;

  modport master (
    input  i_Enable,
    output o_Key,
    output o_Valid,
    output o_Break,
    output o_Ext,
    output o_Err,
    output o_Busy
  );

  modport slave (
    output i_Enable,
    input  o_Key,
    input  o_Valid,
    input  o_Break,
    input  o_Ext,
    input  o_Err,
    input  o_Busy
  );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard front end: sync, clock filter, frame deserialiser,
// E0/F0 prefix folding and timeout abort.
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              PS2C,
  input  logic              PS2D,
  ps2_scan_receiver_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]            c_s;
  logic [1:0]            d_s;
  logic [FILTER_LEN-1:0] filt;
  logic                  fclk;
  logic                  fclk_d;
  logic                  strobe;
  logic                  din;

  state_t                state;
  logic [7:0]            shreg;
  logic [2:0]            bitcnt;
  logic                  par;
  logic                  ext_f;
  logic                  brk_f;
  logic [TW-1:0]         tcnt;

  logic [7:0]            key_q;
  logic                  valid_q;
  logic                  brk_q;
  logic                  ext_q;
  logic                  err_q;

  assign din    = d_s[1];
  assign strobe = fclk_d & ~fclk;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      c_s    <= 2'b11;
      d_s    <= 2'b11;
      filt   <= '1;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
    end else begin
      c_s    <= {c_s[0], PS2C};
      d_s    <= {d_s[0], PS2D};
      filt   <= {filt[FILTER_LEN-2:0], c_s[1]};
      fclk_d <= fclk;
      if (filt == '0)
        fclk <= 1'b0;
      else if (&filt)
        fclk <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      par     <= 1'b0;
      ext_f   <= 1'b0;
      brk_f   <= 1'b0;
      tcnt    <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!bus.i_Enable) begin
        state <= IDLE;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
        tcnt  <= '0;
      end else if (strobe) begin
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (!din) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {din, shreg[7:1]};
            bitcnt <= 3'(bitcnt + 3'd1);
            if (bitcnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (din && (^shreg ^ par)) begin
              unique case (1'b1)
                (shreg == 8'hE0): ext_f <= 1'b1;
                (shreg == 8'hF0): brk_f <= 1'b1;
                default: begin
                  key_q   <= shreg;
                  brk_q   <= brk_f;
                  ext_q   <= ext_f;
                  valid_q <= 1'b1;
                  ext_f   <= 1'b0;
                  brk_f   <= 1'b0;
                end
              endcase
            end else begin
              err_q <= 1'b1;
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYC)) begin
        // Device stalled mid-frame: drop it and flag the loss.
        state <= IDLE;
        err_q <= 1'b1;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
        tcnt  <= '0;
      end else begin
        tcnt <= TW'(tcnt + 1'b1);
      end
    end
  end

  assign bus.o_Key   = key_q;
  assign bus.o_Valid = valid_q;
  assign bus.o_Break = brk_q;
  assign bus.o_Ext   = ext_q;
  assign bus.o_Err   = err_q;
  assign bus.o_Busy  = (state != IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: pin-level PS/2 frames, event-level
// reference model of prefix folding and error handling.
module tb_ps2_scan_receiver;

  localparam int FL = 8;
  localparam int TO = 300;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  logic PS2C  = 1'b1;
  logic PS2D  = 1'b1;

  ps2_scan_receiver_if bus();

  ps2_scan_receiver #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .PS2C  (PS2C),
    .PS2D  (PS2D),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic       err;
    logic [7:0] key;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  logic prev_pulse = 1'b0;

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_key = 8'h00;
  logic       m_kbrk = 1'b0;
  logic       m_kext = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_Clk) begin
    if (bus.o_Valid)
      got_q.push_back({1'b0, bus.o_Key, bus.o_Break, bus.o_Ext});
    if (bus.o_Err)
      got_q.push_back({1'b1, 8'h00, 1'b0, 1'b0});
    if (bus.o_Valid && bus.o_Err)
      viol++;
    if ((bus.o_Valid || bus.o_Err) && prev_pulse)
      viol++;
    prev_pulse = bus.o_Valid || bus.o_Err;
  end

  // Reference model: what a host sees per received frame.
  task automatic model_frame(input logic [7:0] b, input logic bad_f);
    if (bad_f) begin
      exp_q.push_back({1'b1, 8'h00, 1'b0, 1'b0});
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back({1'b0, b, m_brk, m_ext});
      m_key  = b;
      m_kbrk = m_brk;
      m_kext = m_ext;
      m_ext  = 0;
      m_brk  = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch,
                          input int half);
    PS2D = b;
    if (glitch) begin
      wait_cyc(12);
      PS2C = 1'b0;
      wait_cyc(FL - 1);
      PS2C = 1'b1;
      wait_cyc(half - 12 - (FL - 1));
    end else begin
      wait_cyc(half);
    end
    PS2C = 1'b0;
    wait_cyc(half);
    PS2C = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pbad,
                            input logic sbad, input logic gl,
                            input int half);
    logic [10:0] bits;
    bits = {~sbad, ~(^b) ^ pbad, b, 1'b0};
    for (int i = 0; i < 11; i++)
      send_bit(bits[i], gl && ($urandom_range(0, 1) == 1), half);
    PS2D = 1'b1;
    wait_cyc(40);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 32);
    model_frame(b, 1'b0);
  endtask

  task automatic compare(input string tag);
    int n;
    wait_cyc(5);
    chk({tag, "_evcount"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_key"}, {bus.o_Key, bus.o_Break, bus.o_Ext},
        {m_key, m_kbrk, m_kext});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       pb;
    logic       sb;
    logic [3:0] tbits;

    bus.i_Enable = 1'b1;
    wait_cyc(5);
    chk("reset_out", {bus.o_Key, bus.o_Valid, bus.o_Break, bus.o_Ext,
                      bus.o_Err, bus.o_Busy}, 0);
    i_Rst = 1'b1;
    wait_cyc(20);

    good(8'h1C);
    compare("make");

    good(8'hF0);
    good(8'h1C);
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    compare("extbrk");

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 32);
    model_frame(8'h1C, 1'b1);
    compare("parerr");
    good(8'hE0);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 32);
    model_frame(8'h33, 1'b1);
    good(8'h74);
    compare("stoperr");

    // Timeout: start + 4 bits, then the clock stays high.
    tbits = 4'($urandom);
    PS2D = 1'b0;
    wait_cyc(20);
    PS2C = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wait_cyc(1);
      if (k == FL + 3) chk("lat_busy_early", bus.o_Busy, 0);
      if (k == FL + 4) chk("lat_busy", bus.o_Busy, 1);
    end
    PS2C = 1'b1;
    for (int i = 0; i < 3; i++)
      send_bit(tbits[i], 1'b0, 24);
    PS2D = tbits[3];
    wait_cyc(24);
    PS2C = 1'b0;
    // Strobe lands FL+3 cycles after the fall; counter idles from the
    // next cycle and the error shows one cycle after it hits TO.
    for (int k = 1; k <= FL + 5 + TO; k++) begin
      wait_cyc(1);
      if (k == 24) PS2C = 1'b1;
      if (k == FL + 4 + TO)
        chk("to_pre", {bus.o_Err, bus.o_Busy}, 2'b01);
      if (k == FL + 5 + TO)
        chk("to_hit", {bus.o_Err, bus.o_Busy}, 2'b10);
    end
    PS2D = 1'b1;
    exp_q.push_back({1'b1, 8'h00, 1'b0, 1'b0});
    m_ext = 0;
    m_brk = 0;
    wait_cyc(20);
    good(8'h29);
    compare("timeout");

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      pb = ($urandom_range(0, 9) == 0);
      sb = ($urandom_range(0, 9) == 0);
      send_frame(b, pb, sb, 1'b1, $urandom_range(32, 40));
      model_frame(b, pb | sb);
    end
    compare("rand");

    // Disable after data bit 5, then a frame while disabled.
    good(8'hE0);
    b = 8'h5A;
    send_bit(1'b0, 1'b0, 32);
    for (int i = 0; i < 5; i++)
      send_bit(b[i], 1'b0, 32);
    bus.i_Enable = 1'b0;
    m_ext = 0;
    m_brk = 0;
    for (int i = 5; i < 8; i++)
      send_bit(b[i], 1'b0, 32);
    send_bit(~(^b), 1'b0, 32);
    send_bit(1'b1, 1'b0, 32);
    PS2D = 1'b1;
    wait_cyc(40);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 32);
    bus.i_Enable = 1'b1;
    wait_cyc(10);
    good(8'h29);
    compare("disable");

    // Asynchronous reset mid-frame.
    b = 8'h3C;
    send_bit(1'b0, 1'b0, 32);
    for (int i = 0; i < 3; i++)
      send_bit(b[i], 1'b0, 32);
    chk("rst_busy_before", bus.o_Busy, 1);
    #3;
    i_Rst = 1'b0;
    #1;
    chk("rst_async", {bus.o_Key, bus.o_Valid, bus.o_Break, bus.o_Ext,
                      bus.o_Err, bus.o_Busy}, 0);
    PS2D = 1'b1;
    wait_cyc(5);
    i_Rst = 1'b1;
    m_ext  = 0;
    m_brk  = 0;
    m_key  = 8'h00;
    m_kbrk = 0;
    m_kext = 0;
    wait_cyc(20);
    good(8'h6B);
    compare("reset");

    chk("pulse_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
